// File: rtl/pool_pkg.sv
// Shared types, geometry helpers and the signed max used by the 2x2 max-pooling stage.
package pool_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int MAP_W_DEF = 13;
    localparam int MAP_H_DEF = 13;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Largest even extent that fits in n; a trailing odd row/column is not pooled.
    function automatic int pooled_dim(input int n);
        return 2 * (n / 2);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    localparam int PW         = pooled_dim(MAP_W_DEF);
    localparam int PH         = pooled_dim(MAP_H_DEF);
    localparam int LBUF_DEPTH = MAP_W_DEF / 2;

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer of per-pair partial maxima: synchronous write, combinational read.
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int DEPTH = LBUF_DEPTH,
    parameter int DW    = SAMPLE_W,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    // No reset: every entry is written on an even row before the odd row reads it.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pool_stage.sv
// 2x2 stride-2 signed max-pooling over a raster stream, single output register.
// Build option POOL_RELU_EN clamps negative results to zero before they are registered.
module pool_stage
    import pool_pkg::*;
#(
    parameter int DW    = SAMPLE_W,
    parameter int MAP_W = MAP_W_DEF,
    parameter int MAP_H = MAP_H_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          frame_done
);

    localparam int POOL_W = pooled_dim(MAP_W);
    localparam int POOL_H = pooled_dim(MAP_H);
    localparam int DEPTH  = MAP_W / 2;
    localparam int CW     = idx_width(MAP_W);
    localparam int RW     = idx_width(MAP_H);
    localparam int IW     = idx_width(DEPTH);

    localparam logic [CW-1:0] COL_LAST    = CW'(MAP_W - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(MAP_H - 1);
    localparam logic [CW-1:0] COL_PW_LAST = CW'(POOL_W - 1);
    localparam logic [RW-1:0] ROW_PH_LAST = RW'(POOL_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    sample_t       pair;
    sample_t       sample_in;
    sample_t       lb_rd;
    sample_t       max_val;
    sample_t       result;
    logic [IW-1:0] lb_idx;

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          in_region;
    logic          lb_wr;
    logic          produce;
    logic          pos_out_last;

    sample_t       out_data_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          frame_done_q;

    assign in_ready     = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign sample_in    = sample_t'(in_data);

    assign col_last     = (col == COL_LAST);
    assign row_last     = (row == ROW_LAST);
    assign in_region    = (col <= COL_PW_LAST) && (row <= ROW_PH_LAST);
    assign lb_idx       = IW'(col >> 1);
    assign lb_wr        = accept && in_region && col[0] && !row[0];
    assign produce      = accept && in_region && col[0] && row[0];
    assign pos_out_last = (row == ROW_PH_LAST) && (col == COL_PW_LAST);

    pool_line_buffer #(
        .DEPTH (DEPTH),
        .DW    (SAMPLE_W),
        .IW    (IW)
    ) u_lbuf (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_idx  (lb_idx),
        .wr_data (smax(pair, sample_in)),
        .rd_idx  (lb_idx),
        .rd_data (lb_rd)
    );

    always_comb begin
        max_val = smax(lb_rd, smax(pair, sample_in));
`ifdef POOL_RELU_EN
        result  = max_val[SAMPLE_W-1] ? '0 : max_val;
`else
        result  = max_val;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            pair <= '0;
        end else if (accept) begin
            if (!col[0]) begin
                pair <= sample_in;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // A producing accept implies the register is empty or draining, so reload without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && col_last && row_last;
            if (produce) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
                out_last_q  <= pos_out_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_stage.sv
// Directed bench for pool_stage: a 4x4 and a 5x5 instance share one stimulus port set.
module tb_pool_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        rdy4, rdy5, ov4, ov5, ol4, ol5, fd4, fd5;
    logic [15:0] od4, od5;

    logic        in_ready, out_valid, out_last, frame_done;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    pool_stage #(.DW(16), .MAP_W(4), .MAP_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(rdy4),
        .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_last(ol4), .frame_done(fd4)
    );

    pool_stage #(.DW(16), .MAP_W(5), .MAP_H(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(rdy5),
        .in_data(in_data), .out_valid(ov5), .out_ready(out_ready),
        .out_data(od5), .out_last(ol5), .frame_done(fd5)
    );

    assign in_ready   = sel ? rdy5 : rdy4;
    assign out_valid  = sel ? ov5  : ov4;
    assign out_data   = sel ? od5  : od4;
    assign out_last   = sel ? ol5  : ol4;
    assign frame_done = sel ? fd5  : fd4;

    int passed = 0;
    int total  = 0;

    logic signed [15:0] got_data[$];
    int                 got_last[$];
    int                 fd_count;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(int'(out_last));
        end
        if (frame_done) fd_count++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send(input logic [15:0] v);
        int tries = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        check("accept_in_time", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h7abc;
    endtask

    task automatic clear_capture();
        got_data.delete();
        got_last.delete();
        fd_count = 0;
    endtask

    // Called just after the final accept; checks the frame_done pulse, then the pooled outputs.
    task automatic finish_frame(input string tag, input logic [63:0] exp);
        int e;
        int a;
        @(negedge clk);
        check({tag, "_fd_pulse"}, int'(frame_done), 1);
        @(negedge clk);
        check({tag, "_fd_one_cycle"}, int'(frame_done), 0);
        repeat (3) @(negedge clk);
        check({tag, "_out_count"}, got_data.size(), 4);
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            e = $signed(exp[16*k +: 16]);
            a = got_data[k];
            check($sformatf("%s_data%0d", tag, k), a, e);
            check($sformatf("%s_last%0d", tag, k), got_last[k], (k == 3) ? 1 : 0);
        end
        check({tag, "_fd_count"}, fd_count, 1);
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        logic [15:0] a16, b16, c16, d16;
        a16 = 16'(a); b16 = 16'(b); c16 = 16'(c); d16 = 16'(d);
        return {d16, c16, b16, a16};
    endfunction

    typedef struct {
        string       name;
        logic        sel;
        int          n;
        int          start;
        int          step;
        logic [63:0] exp_raw;
        logic [63:0] exp_relu;
    } vec_t;

    vec_t vecs[4];
    logic [63:0] exp_sel;

    initial begin
        vecs[0] = '{"ramp4",  1'b0, 16,  0,  1, pack4(5, 7, 13, 15),   pack4(5, 7, 13, 15)};
        vecs[1] = '{"neg4",   1'b0, 16,  0, -1, pack4(0, -2, -8, -10), pack4(0, 0, 0, 0)};
        vecs[2] = '{"ramp5",  1'b1, 25,  0,  1, pack4(6, 8, 16, 18),   pack4(6, 8, 16, 18)};
        vecs[3] = '{"mixed4", 1'b0, 16, -8,  1, pack4(-3, -1, 5, 7),   pack4(0, 0, 5, 7)};

        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        fd_count  = 0;

        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("rst%0d_out_valid", s), int'(out_valid), 0);
            check($sformatf("rst%0d_out_data", s), int'(out_data), 0);
            check($sformatf("rst%0d_out_last", s), int'(out_last), 0);
            check($sformatf("rst%0d_frame_done", s), int'(frame_done), 0);
            check($sformatf("rst%0d_in_ready", s), int'(in_ready), 1);
        end
        #8;
        rst = 1'b0;

        // Frames run back to back: no idle gap between vectors on the same instance.
        for (int v = 0; v < 4; v++) begin
            sel = vecs[v].sel;
            clear_capture();
            for (int i = 0; i < vecs[v].n; i++)
                send(16'(vecs[v].start + vecs[v].step * i));
`ifdef POOL_RELU_EN
            exp_sel = vecs[v].exp_relu;
`else
            exp_sel = vecs[v].exp_raw;
`endif
            finish_frame(vecs[v].name, exp_sel);
        end

        // Backpressure: output 5 held for three cycles while sample 6 waits.
        sel = 1'b0;
        clear_capture();
        for (int i = 0; i < 6; i++) send(16'(i));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_in_ready", k), int'(in_ready), 0);
            check($sformatf("hold%0d_out_valid", k), int'(out_valid), 1);
            check($sformatf("hold%0d_out_data", k), int'($signed(out_data)), 5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 7; i < 16; i++) send(16'(i));
        finish_frame("hold", pack4(5, 7, 13, 15));

        // Reset mid-frame with an output pending, then a full frame.
        clear_capture();
        for (int i = 0; i < 6; i++) send(16'(i));
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        clear_capture();
        for (int i = 0; i < 16; i++) send(16'(i));
        finish_frame("after_rst", pack4(5, 7, 13, 15));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pool_stage.md
Name: pool_stage

Overview:
- Downstream consumer of the convolution engine's per-filter output feature map.
- Applies 2x2, stride-2 max-pooling to a raster-ordered stream of signed results, one element per handshake.
- Emits the pooled map in raster order with a last-element marker, for the result writer.
- Holds one half-width line buffer of partial maxima, so no full-frame storage is needed.

Parameters:
- DW, 16, width of the signed input and output samples.
- MAP_W, 13, columns of the input feature map, 2 or more.
- MAP_H, 13, rows of the input feature map, 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid sample.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  DW  signed convolution result, raster order.
- out_valid  output  1  out_data holds a valid pooled sample.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DW  signed pooled sample.
- out_last  output  1  qualifies the final pooled sample of a frame.
- frame_done  output  1  one-cycle pulse when the last input sample of a frame is accepted.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, frame_done=0.
  - Row counter, column counter and pair register = 0.
  - Line buffer contents are don't-care; every entry is written before it is read.
- Accept: a sample is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, i.e. one output register with pass-through on drain.
- Position counters:
  - col advances 0..MAP_W-1 on each accept and wraps to 0 while incrementing row.
  - row wraps 0..MAP_H-1. The frame ends on the accept at row=MAP_H-1, col=MAP_W-1; both counters return to 0.
- Pooled region: only columns and rows below PW=2*(MAP_W/2) and PH=2*(MAP_H/2) are pooled.
  - A trailing odd column or row is accepted and discarded.
  - frame_done still pulses on the true last sample.
- Pooling, with pooled index i = col/2:
  - Even col: pair <= in_data.
  - Odd col, even row: lbuf[i] <= max(pair, in_data).
  - Odd col, odd row: result = max(lbuf[i], pair, in_data).
  - All comparisons are signed, DW bits; no width growth.
- Output:
  - result is registered. out_valid is asserted the cycle after the producing accept (latency 1).
  - out_valid holds with stable out_data and out_last until out_ready.
  - If a new result is produced in the same cycle the current one drains, the register reloads with no bubble.
- out_last = 1 with the result from row=PH-1, col=PW-1.
- frame_done: registered, asserted the cycle after the final accept, for one cycle, independent of out_ready.
- Back-to-back frames: no idle cycle is required between frames. The next frame's row 0 may be accepted while the prior out_last is pending, subject to in_ready.
- Reset mid-frame: all counters and out_valid clear immediately. The partial frame is lost and the next accepted sample is row 0, col 0.
- in_data is ignored when not accepted. No combinational path from in_valid to out_valid.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: result is clamped at zero before registering (negative values become 0), fusing ReLU.
- Undefined: the raw signed maximum is output unchanged.
- Handshake and latency are identical in both builds.

Decomposition:
- Package pool_pkg: the signed sample typedef of width DW, the helper function smax(a,b), and localparams PW, PH and LBUF_DEPTH=MAP_W/2.
- One sub-module, pool_line_buffer:
  - Depth LBUF_DEPTH, width DW.
  - Synchronous write, combinational read, index width $clog2(LBUF_DEPTH).
- Counters, pair register and output register stay in pool_stage.

Test Plan:
- MAP_W=4, MAP_H=4, input 0..15 streamed with out_ready=1:
  - Outputs 5, 7, 13, 15, with out_last on 15.
  - frame_done pulses once, the cycle after sample 15.
- Same map with negative values (0 to -15), POOL_RELU_EN undefined:
  - Outputs 0, -2, -8, -10.
- Same map with negative values, POOL_RELU_EN defined:
  - Outputs 0, 0, 0, 0.
- MAP_W=5, MAP_H=5, input 0..24:
  - Outputs 6, 8, 16, 18.
  - Column 4 and row 4 are discarded; frame_done follows sample 24; out_last is on 18.
- out_ready held low for 3 cycles while output 5 is pending:
  - in_ready=0 throughout; out_data stays 5.
  - No sample is lost and the subsequent outputs are unchanged.
- rst pulsed after 6 samples, then 0..15 resent:
  - No stale output appears.
  - Outputs 5, 7, 13, 15 with correct out_last.
